cpu_pipe_ctrl: RTL and testbench

- Parametrised pipeline-control block for the CPU core.
- Tracks every in-flight instruction from decode to writeback, and produces all of the following:
  - per-stage enables
  - bubbles and flushes
  - RAW-hazard stalls
  - branch/jump handling
  - optional forwarding selects
- Generalises the fixed 5-stage stall detector: stage count and branch-resolution stage are configurable, and two new modes are added (forwarding, and predict-not-taken with flush).

---
 rtl/cpu_pipe_pkg.sv | 30 +++
 rtl/cpu_hazard_match.sv | 31 +++
 rtl/cpu_pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_cpu_pipe_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the CPU pipeline-control slice:
// tracker record layout, stage indices and mode encodings.
package cpu_pipe_pkg;

  // Widest register address any configuration may use; records store
  // wrt_reg zero-extended to this width.
  localparam int unsigned MAX_REG_ADDR_W = 8;

  localparam int unsigned STG_IF = 0;
  localparam int unsigned STG_ID = 1;

  typedef enum int unsigned {
    BYPASS_NONE = 0,
    BYPASS_FWD  = 1
  } bypass_e;

  typedef enum int unsigned {
    JB_STALL      = 0,
    JB_PREDICT_NT = 1
  } jb_mode_e;

  typedef struct packed {
    logic                      valid;
    logic                      wrt_en;
    logic [MAX_REG_ADDR_W-1:0] wrt_reg;
    logic                      is_load;
    logic                      is_jb;
  } stage_rec_t;

endpackage

// File: rtl/cpu_hazard_match.sv
// Compares one ID source register against the in-flight tracker records and
// reports any match, the youngest matching stage and a load-in-stage-2 match.
module cpu_hazard_match
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned IDX_W      = 3
) (
  input  logic [MAX_REG_ADDR_W-1:0]   src,
  input  logic                        src_en,
  input  stage_rec_t [NUM_STAGES-1:2] recs,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx,
  output logic                        load2
);

  // Scan oldest to youngest so the lowest matching stage index wins.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    load2 = 1'b0;
    for (int unsigned s = NUM_STAGES - 1; s >= 2; s--) begin
      if (src_en && recs[s].valid && recs[s].wrt_en && (recs[s].wrt_reg == src)) begin
        hit   = 1'b1;
        idx   = IDX_W'(s);
        load2 = (s == 2) && recs[s].is_load;
      end
    end
  end

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline control: tracks in-flight instructions from ID to WB and derives
// stage enables, bubbles, flushes, RAW/jb stalls, redirects and forward selects.
module cpu_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = 5,
  parameter int unsigned REG_ADDR_W    = 4,
  parameter int unsigned RESOLVE_STAGE = 2,
  parameter int unsigned BYPASS        = 0,
  parameter int unsigned JB_MODE       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ext_hold,
  input  logic                          dec_valid,
  input  logic [REG_ADDR_W-1:0]         dec_src1,
  input  logic [REG_ADDR_W-1:0]         dec_src2,
  input  logic                          dec_src1_en,
  input  logic                          dec_src2_en,
  input  logic [REG_ADDR_W-1:0]         dec_wrt_reg,
  input  logic                          dec_wrt_en,
  input  logic                          dec_is_load,
  input  logic                          dec_is_jb,
  input  logic                          jb_taken,
  output logic                          pc_en,
  output logic                          ifid_en,
  output logic                          ifid_flush,
  output logic [NUM_STAGES-3:0]         stage_en,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic                          stall_rw,
  output logic                          stall_jb,
  output logic                          redirect,
  output logic [$clog2(NUM_STAGES)-1:0] fwd_sel1,
  output logic [$clog2(NUM_STAGES)-1:0] fwd_sel2
);

  localparam int unsigned IDX_W      = $clog2(NUM_STAGES);
  localparam bit          FWD_ON     = (BYPASS == BYPASS_FWD);
  localparam bit          PREDICT_NT = (JB_MODE == JB_PREDICT_NT);

  stage_rec_t [NUM_STAGES-1:2] recs;
  stage_rec_t                  dec_rec;

  logic             hit1, hit2, ld1, ld2;
  logic [IDX_W-1:0] idx1, idx2;
  logic             stall_rw_c, stall_jb_c, redirect_c, jb_pending;

  cpu_hazard_match #(
    .NUM_STAGES(NUM_STAGES),
    .IDX_W     (IDX_W)
  ) u_match1 (
    .src   (MAX_REG_ADDR_W'(dec_src1)),
    .src_en(dec_src1_en),
    .recs  (recs),
    .hit   (hit1),
    .idx   (idx1),
    .load2 (ld1)
  );

  cpu_hazard_match #(
    .NUM_STAGES(NUM_STAGES),
    .IDX_W     (IDX_W)
  ) u_match2 (
    .src   (MAX_REG_ADDR_W'(dec_src2)),
    .src_en(dec_src2_en),
    .recs  (recs),
    .hit   (hit2),
    .idx   (idx2),
    .load2 (ld2)
  );

  always_comb begin
    dec_rec = '0;
    if (dec_valid) begin
      dec_rec.valid   = 1'b1;
      dec_rec.wrt_en  = dec_wrt_en;
      dec_rec.wrt_reg = MAX_REG_ADDR_W'(dec_wrt_reg);
      dec_rec.is_load = dec_is_load;
      dec_rec.is_jb   = dec_is_jb;
    end
  end

  always_comb begin
    stall_rw_c = dec_valid & (FWD_ON ? (ld1 | ld2) : (hit1 | hit2));
    jb_pending = dec_valid & dec_is_jb;
    for (int unsigned s = 2; s < RESOLVE_STAGE; s++) begin
      jb_pending = jb_pending | (recs[s].valid & recs[s].is_jb);
    end
    stall_jb_c = ~PREDICT_NT & jb_pending & ~rst;
    // A held pipe must not redirect: jb_taken is sampled again once released.
    redirect_c = recs[RESOLVE_STAGE].valid & recs[RESOLVE_STAGE].is_jb
               & jb_taken & ~ext_hold & ~rst;
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    stage_en    = '0;
    stage_valid = '0;
    stall_rw    = 1'b0;
    stall_jb    = 1'b0;
    redirect    = 1'b0;
    fwd_sel1    = '0;
    fwd_sel2    = '0;
    if (rst) begin
      ifid_flush = 1'b1;
    end else begin
      stage_valid[STG_IF] = 1'b1;
      stage_valid[STG_ID] = dec_valid;
      for (int unsigned s = 2; s < NUM_STAGES; s++) begin
        stage_valid[s] = recs[s].valid;
      end
      stall_rw = stall_rw_c & ~redirect_c;
      stall_jb = stall_jb_c;
      redirect = redirect_c;
      if (FWD_ON && dec_valid && !stall_rw_c) begin
        fwd_sel1 = hit1 ? idx1 : '0;
        fwd_sel2 = hit2 ? idx2 : '0;
      end
      if (!ext_hold) begin
        stage_en = '1;
        if (redirect_c) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else if (stall_rw_c) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
        end else if (stall_jb_c) begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end
    end
  end

  // On redirect, records leaving stages 2..RESOLVE_STAGE-1 are wrong-path and
  // land as bubbles in stages 3..RESOLVE_STAGE.
  always_ff @(posedge clk) begin
    if (rst) begin
      recs <= '0;
    end else if (!ext_hold) begin
      if (redirect_c || stall_rw_c) recs[2] <= '0;
      else                          recs[2] <= dec_rec;
      for (int unsigned s = 3; s < NUM_STAGES; s++) begin
        if (redirect_c && (s <= RESOLVE_STAGE)) recs[s] <= '0;
        else                                    recs[s] <= recs[s-1];
      end
    end
  end

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Directed bench for cpu_pipe_ctrl: four configurations share one stimulus
// stream (defaults, forwarding, stall-on-jb at stage 3, predict-not-taken).
module tb_cpu_pipe_ctrl;

  localparam int unsigned NS   = 5;
  localparam int unsigned NDUT = 4;
  localparam int unsigned RES [NDUT] = '{2, 2, 3, 3};
  localparam int unsigned BYP [NDUT] = '{0, 1, 0, 0};
  localparam int unsigned JBM [NDUT] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       rst, ext_hold, dec_valid, jb_taken;
  logic [3:0] dec_src1, dec_src2, dec_wrt_reg;
  logic       dec_src1_en, dec_src2_en, dec_wrt_en, dec_is_load, dec_is_jb;

  logic          pc_en [NDUT];
  logic          ifid_en [NDUT];
  logic          ifid_flush [NDUT];
  logic [NS-3:0] stage_en [NDUT];
  logic [NS-1:0] stage_valid [NDUT];
  logic          stall_rw [NDUT];
  logic          stall_jb [NDUT];
  logic          redirect [NDUT];
  logic [2:0]    fwd1 [NDUT];
  logic [2:0]    fwd2 [NDUT];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cpu_pipe_ctrl #(
      .NUM_STAGES   (NS),
      .REG_ADDR_W   (4),
      .RESOLVE_STAGE(RES[g]),
      .BYPASS       (BYP[g]),
      .JB_MODE      (JBM[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ext_hold   (ext_hold),
      .dec_valid  (dec_valid),
      .dec_src1   (dec_src1),
      .dec_src2   (dec_src2),
      .dec_src1_en(dec_src1_en),
      .dec_src2_en(dec_src2_en),
      .dec_wrt_reg(dec_wrt_reg),
      .dec_wrt_en (dec_wrt_en),
      .dec_is_load(dec_is_load),
      .dec_is_jb  (dec_is_jb),
      .jb_taken   (jb_taken),
      .pc_en      (pc_en[g]),
      .ifid_en    (ifid_en[g]),
      .ifid_flush (ifid_flush[g]),
      .stage_en   (stage_en[g]),
      .stage_valid(stage_valid[g]),
      .stall_rw   (stall_rw[g]),
      .stall_jb   (stall_jb[g]),
      .redirect   (redirect[g]),
      .fwd_sel1   (fwd1[g]),
      .fwd_sel2   (fwd2[g])
    );
  end

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dec_valid   = 1'b0;
    dec_src1    = '0;
    dec_src2    = '0;
    dec_src1_en = 1'b0;
    dec_src2_en = 1'b0;
    dec_wrt_reg = '0;
    dec_wrt_en  = 1'b0;
    dec_is_load = 1'b0;
    dec_is_jb   = 1'b0;
  endtask

  task automatic set_dec(input logic [3:0] s1, input logic s1e, input logic [3:0] s2,
                         input logic s2e, input logic [3:0] wr, input logic we,
                         input logic ld, input logic jb);
    dec_valid   = 1'b1;
    dec_src1    = s1;
    dec_src1_en = s1e;
    dec_src2    = s2;
    dec_src2_en = s2e;
    dec_wrt_reg = wr;
    dec_wrt_en  = we;
    dec_is_load = ld;
    dec_is_jb   = jb;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ext_hold = 1'b0;
    jb_taken = 1'b0;
    idle();
    advance();
    rst = 1'b0;
  endtask

  logic [4:0] t1_sv [4] = '{5'b00111, 5'b01011, 5'b10011, 5'b00011};

  initial begin
    // Reset values, with a live instruction presented in ID.
    rst = 1'b1; ext_hold = 1'b0; jb_taken = 1'b0;
    set_dec(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    settle();
    for (int d = 0; d < NDUT; d++) begin
      check_eq("rst pc_en", pc_en[d], 1'b0);
      check_eq("rst ifid_en", ifid_en[d], 1'b0);
      check_eq("rst ifid_flush", ifid_flush[d], 1'b1);
      check_eq("rst stage_en", stage_en[d], 3'b000);
      check_eq("rst stage_valid", stage_valid[d], 5'b00000);
      check_eq("rst stall_rw", stall_rw[d], 1'b0);
      check_eq("rst stall_jb", stall_jb[d], 1'b0);
      check_eq("rst redirect", redirect[d], 1'b0);
    end
    advance();
    rst = 1'b0;

    // RAW: producer r3 then reader r3.
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    settle();
    check_eq("raw first pc_en", pc_en[0], 1'b1);
    check_eq("raw first valid", stage_valid[0], 5'b00011);
    advance();
    set_dec(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      settle();
      check_eq("raw stall_rw", stall_rw[0], c < 3);
      check_eq("raw pc_en", pc_en[0], c >= 3);
      check_eq("raw ifid_en", ifid_en[0], c >= 3);
      check_eq("raw stage_valid", stage_valid[0], t1_sv[c]);
      check_eq("raw fwd1", fwd1[0], 3'd0);
      check_eq("byp no stall", stall_rw[1], 1'b0);
      check_eq("byp fwd1", fwd1[1], (c < 3) ? 3'(c + 2) : 3'd0);
      advance();
    end
    idle();
    settle();
    check_eq("raw dependent in stage2", stage_valid[0], 5'b00101);
    do_reset();

    // Load-use with BYPASS = 1 on source 2.
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    settle();
    advance();
    set_dec(4'd5, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_eq("ldu stall_rw", stall_rw[1], 1'b1);
    check_eq("ldu pc_en", pc_en[1], 1'b0);
    check_eq("ldu fwd2 stalled", fwd2[1], 3'd0);
    check_eq("ldu nobyp stall", stall_rw[0], 1'b1);
    advance();
    settle();
    check_eq("ldu released", stall_rw[1], 1'b0);
    check_eq("ldu pc_en2", pc_en[1], 1'b1);
    check_eq("ldu fwd2", fwd2[1], 3'd3);
    check_eq("ldu fwd1 disabled", fwd1[1], 3'd0);
    check_eq("ldu stage_valid", stage_valid[1], 5'b01011);
    do_reset();

    // jb in ID: stall modes vs predict-not-taken.
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    settle();
    check_eq("jb0 stall A", stall_jb[2], 1'b1);
    check_eq("jb0 flush A", ifid_flush[2], 1'b1);
    check_eq("jb0 pc_en A", pc_en[2], 1'b0);
    check_eq("jb0 ifid_en A", ifid_en[2], 1'b1);
    check_eq("jb0 r2 stall A", stall_jb[0], 1'b1);
    check_eq("jb1 no stall", stall_jb[3], 1'b0);
    check_eq("jb1 pc_en A", pc_en[3], 1'b1);
    advance();
    idle();
    settle();
    check_eq("jb0 stall B", stall_jb[2], 1'b1);
    check_eq("jb0 flush B", ifid_flush[2], 1'b1);
    check_eq("jb0 pc_en B", pc_en[2], 1'b0);
    check_eq("jb0 r2 stall B", stall_jb[0], 1'b0);
    check_eq("jb0 r2 pc_en B", pc_en[0], 1'b1);
    advance();
    jb_taken = 1'b1;
    settle();
    check_eq("jb0 stall C", stall_jb[2], 1'b0);
    check_eq("jb0 redirect", redirect[2], 1'b1);
    check_eq("jb0 pc_en C", pc_en[2], 1'b1);
    check_eq("jb0 flush C", ifid_flush[2], 1'b1);
    check_eq("jb1 redirect C", redirect[3], 1'b1);
    advance();
    settle();
    check_eq("jb0 past resolve", redirect[2], 1'b0);
    do_reset();

    // Predict-not-taken flush of wrong-path work.
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    settle();
    check_eq("pnt flush A", ifid_flush[3], 1'b0);
    advance();
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    settle();
    check_eq("pnt redirect early", redirect[3], 1'b0);
    advance();
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
    jb_taken = 1'b1;
    settle();
    check_eq("pnt redirect", redirect[3], 1'b1);
    check_eq("pnt flush", ifid_flush[3], 1'b1);
    check_eq("pnt pc_en", pc_en[3], 1'b1);
    check_eq("pnt valid before", stage_valid[3], 5'b01111);
    advance();
    idle();
    jb_taken = 1'b0;
    settle();
    check_eq("pnt valid after", stage_valid[3], 5'b10001);
    advance();
    set_dec(4'd7, 1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_eq("pnt killed no raw", stall_rw[3], 1'b0);
    do_reset();

    // ext_hold over a RAW stall with a taken jb waiting at resolve.
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1);
    settle();
    advance();
    set_dec(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_eq("hold pre stall_rw", stall_rw[3], 1'b1);
    check_eq("hold pre pc_en", pc_en[3], 1'b0);
    advance();
    jb_taken = 1'b1;
    ext_hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check_eq("hold pc_en", pc_en[3], 1'b0);
      check_eq("hold ifid_en", ifid_en[3], 1'b0);
      check_eq("hold stage_en", stage_en[3], 3'b000);
      check_eq("hold redirect", redirect[3], 1'b0);
      check_eq("hold stage_valid", stage_valid[3], 5'b01011);
      advance();
    end
    ext_hold = 1'b0;
    settle();
    check_eq("rel redirect", redirect[3], 1'b1);
    check_eq("rel pc_en", pc_en[3], 1'b1);
    check_eq("rel ifid_en", ifid_en[3], 1'b1);
    check_eq("rel ifid_flush", ifid_flush[3], 1'b1);
    check_eq("rel stall_rw", stall_rw[3], 1'b0);
    check_eq("rel stage_en", stage_en[3], 3'b111);
    advance();
    idle();
    jb_taken = 1'b0;
    settle();
    check_eq("rel stage_valid", stage_valid[3], 5'b10001);
    do_reset();

    // Reset while three records are valid.
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    advance();
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    advance();
    set_dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    advance();
    settle();
    check_eq("full stage_valid", stage_valid[0], 5'b11111);
    rst = 1'b1;
    #1;
    check_eq("midrst stage_valid", stage_valid[0], 5'b00000);
    check_eq("midrst pc_en", pc_en[0], 1'b0);
    check_eq("midrst ifid_flush", ifid_flush[0], 1'b1);
    advance();
    rst = 1'b0;
    idle();
    settle();
    check_eq("postrst stage_valid", stage_valid[0], 5'b00001);
    check_eq("postrst pc_en", pc_en[0], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
